// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//   Instruction memory for the single-cycle RISC-V core. The fetch path reads
//   words through a byte-addressed port driven by the PC. A valid/ready
//   streaming loader fills any contiguous word window starting at a
//   programmable base. After reset the whole array is zeroed by a sweep of
//   one word per cycle.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active-high (restarts the clear sweep)
//   rd_addr      byte address from the PC
//   instruction  fetched word (combinational or registered, see REG_READ)
//   rd_misalign  rd_addr[1:0] != 0, same timing as instruction
//   load_start   single-cycle request to begin a load
//   load_base    first word index to write (sampled on accepted load_start)
//   load_count   number of words 0..DEPTH (sampled on accepted load_start)
//   load_valid   load_data is valid
//   load_data    word to store
//   load_ready   block accepts load_data this cycle
//   busy         clearing or loading
//   load_done    sticky: last requested load completed
//   load_err     sticky: last load_start was rejected as out of range
// ----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int REG_READ = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W+1:0]   rd_addr,
    output logic [DATA_W-1:0]   instruction,
    output logic                rd_misalign,
    input  logic                load_start,
    input  logic [ADDR_W-1:0]   load_base,
    input  logic [ADDR_W:0]     load_count,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_ready,
    output logic                busy,
    output logic                load_done,
    output logic                load_err
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;

    // Range check is done two bits wider than the word index so that
    // base+count can never wrap back into the legal range.
    logic [ADDR_W+1:0] load_end;
    logic              range_bad;

    assign load_end  = {2'b00, load_base} + {1'b0, load_count};
    assign range_bad = ({1'b0, load_count} > DEPTH_EXT) || (load_end > DEPTH_EXT);

    assign busy       = (state != S_IDLE);
    assign load_ready = (state == S_LOAD);

    // Single write port shared by the clear sweep and the loader.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_ptr;
        wr_data = '0;
        if (!rst) begin
            case (state)
                S_CLEAR: wr_en = 1'b1;
                S_LOAD: begin
                    wr_en   = load_valid;
                    wr_idx  = ptr;
                    wr_data = load_data;
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_ptr   <= '0;
            ptr       <= '0;
            remaining <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_IDX) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (load_start) begin
                        if (range_bad) begin
                            load_done <= 1'b0;
                            load_err  <= 1'b1;
                        end else if (load_count == '0) begin
                            load_done <= 1'b1;
                            load_err  <= 1'b0;
                        end else begin
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            ptr       <= load_base;
                            remaining <= load_count;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state     <= S_IDLE;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Misaligned fetches still return the aligned word; the core traps.
    logic [ADDR_W-1:0] rd_idx;
    assign rd_idx = rd_addr[ADDR_W+1:2];

    generate
        if (REG_READ != 0) begin : g_reg_read
            always_ff @(posedge clk) begin
                if (rst) begin
                    instruction <= '0;
                    rd_misalign <= 1'b0;
                end else begin
                    instruction <= mem[rd_idx];
                    rd_misalign <= |rd_addr[1:0];
                end
            end
        end else begin : g_comb_read
            assign instruction = mem[rd_idx];
            assign rd_misalign = |rd_addr[1:0];
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam logic [31:0] W0 = 32'h00500093;
    localparam logic [31:0] W1 = 32'h00A00113;
    localparam logic [31:0] W2 = 32'h002081B3;
    localparam logic [31:0] D0 = 32'hCAFE0001;
    localparam logic [31:0] D1 = 32'hBEEF0002;
    localparam logic [31:0] NW = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic        load_start = 1'b0;
    logic [7:0]  load_base = '0;
    logic [8:0]  load_count = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;

    logic [31:0] instr_c, instr_r;
    logic        mis_c, mis_r;
    logic        ready_c, ready_r, busy_c, busy_r, done_c, done_r, err_c, err_r;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.DATA_W(32), .DEPTH(256), .REG_READ(0)) u_comb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .instruction(instr_c),
        .rd_misalign(mis_c), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_c), .busy(busy_c), .load_done(done_c), .load_err(err_c)
    );

    instr_mem_loader #(.DATA_W(32), .DEPTH(256), .REG_READ(1)) u_reg (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .instruction(instr_r),
        .rd_misalign(mis_r), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_r), .busy(busy_r), .load_done(done_r), .load_err(err_r)
    );

    typedef struct {
        int          phase;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        mis;
    } rd_vec_t;

    rd_vec_t tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string name, input logic b, input logic r,
                            input logic d, input logic e);
        chk({name, "_busy"},  {31'b0, busy_c},  {31'b0, b});
        chk({name, "_ready"}, {31'b0, ready_c}, {31'b0, r});
        chk({name, "_done"},  {31'b0, done_c},  {31'b0, d});
        chk({name, "_err"},   {31'b0, err_c},   {31'b0, e});
        chk({name, "_busy_r"}, {31'b0, busy_r}, {31'b0, b});
        chk({name, "_done_r"}, {31'b0, done_r}, {31'b0, d});
        chk({name, "_err_r"},  {31'b0, err_r},  {31'b0, e});
        chk({name, "_rdy_r"},  {31'b0, ready_r}, {31'b0, r});
    endtask

    // Reads one address through both instances; the registered copy is
    // checked after the following edge.
    task automatic rd(input string name, input logic [9:0] a,
                      input logic [31:0] e, input logic m);
        rd_addr = a;
        #1;
        chk({name, "_comb"},     instr_c, e);
        chk({name, "_comb_mis"}, {31'b0, mis_c}, {31'b0, m});
        step();
        chk({name, "_reg"},      instr_r, e);
        chk({name, "_reg_mis"},  {31'b0, mis_r}, {31'b0, m});
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy_c && n < 300) begin
            step();
            n++;
        end
        chk(name, n, 256);
    endtask

    task automatic start(input logic [7:0] b, input logic [8:0] c);
        load_base  = b;
        load_count = c;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input int gap);
        load_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].phase == p) begin
                rd($sformatf("rd_p%0d_%03h", p, tbl[i].addr), tbl[i].addr,
                   tbl[i].data, tbl[i].mis);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{phase: 1, addr: 10'h000, data: 32'h0, mis: 1'b0};
        tbl[1]  = '{phase: 1, addr: 10'h3FC, data: 32'h0, mis: 1'b0};
        tbl[2]  = '{phase: 2, addr: 10'h010, data: W0,    mis: 1'b0};
        tbl[3]  = '{phase: 2, addr: 10'h014, data: W1,    mis: 1'b0};
        tbl[4]  = '{phase: 2, addr: 10'h018, data: W2,    mis: 1'b0};
        tbl[5]  = '{phase: 2, addr: 10'h00C, data: 32'h0, mis: 1'b0};
        tbl[6]  = '{phase: 2, addr: 10'h01C, data: 32'h0, mis: 1'b0};
        tbl[7]  = '{phase: 2, addr: 10'h000, data: 32'h0, mis: 1'b0};
        tbl[8]  = '{phase: 2, addr: 10'h011, data: W0,    mis: 1'b1};
        tbl[9]  = '{phase: 3, addr: 10'h3F8, data: 32'h0, mis: 1'b0};
        tbl[10] = '{phase: 3, addr: 10'h3FC, data: 32'h0, mis: 1'b0};
        tbl[11] = '{phase: 4, addr: 10'h3FF, data: D1,    mis: 1'b1};

        // Reset and full clear sweep
        step();
        rst = 1'b0;
        chk_ctrl("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_instr_r", instr_r, 32'h0);
        wait_clear("clear_cycles");
        chk_ctrl("after_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        run_phase(1);

        // Load three words at base 4 with gaps; load_start mid-load ignored
        start(8'd4, 9'd3);
        chk_ctrl("load_enter", 1'b1, 1'b1, 1'b0, 1'b0);
        push(W0, 1);
        chk_ctrl("load_w0", 1'b1, 1'b1, 1'b0, 1'b0);
        load_base  = 8'd0;
        load_count = 9'd1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk_ctrl("load_ign", 1'b1, 1'b1, 1'b0, 1'b0);
        push(W1, 2);
        chk_ctrl("load_w1", 1'b1, 1'b1, 1'b0, 1'b0);
        push(W2, 1);
        chk_ctrl("load_w2", 1'b0, 1'b0, 1'b1, 1'b0);
        run_phase(2);

        // Out-of-range window, then the legal one at the top of memory
        start(8'd254, 9'd3);
        chk_ctrl("range_err", 1'b0, 1'b0, 1'b0, 1'b1);
        run_phase(3);
        start(8'd254, 9'd2);
        chk_ctrl("top_enter", 1'b1, 1'b1, 1'b0, 1'b0);
        push(D0, 0);
        push(D1, 0);
        chk_ctrl("top_done", 1'b0, 1'b0, 1'b1, 1'b0);
        rd("rd_top0", 10'h3F8, D0, 1'b0);
        rd("rd_top1", 10'h3FC, D1, 1'b0);
        run_phase(4);

        // Count above DEPTH, then zero-length load
        start(8'd0, 9'd257);
        chk_ctrl("count_err", 1'b0, 1'b0, 1'b0, 1'b1);
        start(8'd0, 9'd256);
        chk_ctrl("full_enter", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_clear("clear_cycles2");
        rd("rd_cleared_w0", 10'h010, 32'h0, 1'b0);
        rd("rd_cleared_top", 10'h3FC, 32'h0, 1'b0);
        start(8'd4, 9'd1);
        push(W0, 0);
        chk_ctrl("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);
        start(8'd10, 9'd0);
        chk_ctrl("zero_len", 1'b0, 1'b0, 1'b1, 1'b0);

        // Read-before-write on the word being loaded
        start(8'd4, 9'd1);
        rd_addr    = 10'h010;
        load_valid = 1'b1;
        load_data  = NW;
        #1;
        chk("rbw_comb_old", instr_c, W0);
        step();
        load_valid = 1'b0;
        chk("rbw_reg_old", instr_r, W0);
        chk("rbw_comb_new", instr_c, NW);
        chk_ctrl("rbw_done", 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("rbw_reg_new", instr_r, NW);

        // Reset after 2 of 5 words: load aborted, array swept
        start(8'd8, 9'd5);
        push(D0, 0);
        push(D1, 1);
        chk_ctrl("abort_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        rd_addr = 10'h011;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_instr_r", instr_r, 32'h0);
        chk("abort_mis_r", {31'b0, mis_r}, 32'h0);
        chk_ctrl("abort_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        wait_clear("clear_cycles3");
        chk_ctrl("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        rd("rd_abort_8", 10'h020, 32'h0, 1'b0);
        rd("rd_abort_9", 10'h024, 32'h0, 1'b0);
        rd("rd_abort_4", 10'h010, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Parametrised instruction memory for the single-cycle RISC-V core.
- Serves the fetch path through a byte-addressed read port driven by the PC.
- Is filled by a valid/ready streaming loader that writes any contiguous window starting at a programmable base.
- Zeroes its whole array after reset with a sweep, not a parallel clear; supports repeated reloads with range checking and status flags.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 256, number of words; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), word-index width; derived, do not override.
- REG_READ, 0, read mode: 0 = combinational read; 1 = registered read with 1-cycle latency.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rd_addr  in  ADDR_W+2  byte address from the PC.
- instruction  out  DATA_W  fetched word.
- rd_misalign  out  1  rd_addr[1:0] != 0; same timing as instruction.
- load_start  in  1  single-cycle request to begin a load.
- load_base  in  ADDR_W  first word index to write; sampled on an accepted load_start.
- load_count  in  ADDR_W+1  number of words, 0..DEPTH; sampled on an accepted load_start.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  word to store.
- load_ready  out  1  block accepts load_data this cycle.
- busy  out  1  block is in state CLEAR or LOAD.
- load_done  out  1  sticky: last requested load completed.
- load_err  out  1  sticky: last load_start was rejected as out of range.

Behaviour:
- States: CLEAR, IDLE, LOAD.
- Reset (rst=1 at posedge): state=CLEAR, clr_ptr=0, load_done=0, load_err=0, load_ready=0, busy=1; registered instruction=0, registered rd_misalign=0.
- CLEAR:
  - Writes 0 to mem[clr_ptr] every cycle and increments clr_ptr.
  - After writing index DEPTH-1, goes to IDLE. CLEAR takes exactly DEPTH cycles.
  - load_start is ignored; load_ready=0.
- IDLE:
  - busy=0, load_ready=0.
  - On load_start, load_done and load_err clear in the same cycle, then:
    - load_count > DEPTH, or load_base+load_count > DEPTH (computed at ADDR_W+2 bits, no wrap): load_err=1, no writes, stay in IDLE.
    - load_count == 0: load_done=1 next cycle, stay in IDLE.
    - otherwise: ptr=load_base, remaining=load_count, go to LOAD.
- LOAD:
  - busy=1; load_ready=1 every cycle in this state (no backpressure).
  - Each cycle with load_valid=1: mem[ptr]<=load_data, ptr++, remaining--.
  - When the write consumes the last remaining word: go to IDLE and set load_done=1 on that same edge. load_ready=0 from the next cycle.
  - load_valid=0 stalls with no state change.
  - load_start is ignored.
- The stream never wraps; the range check guarantees ptr stays at or below DEPTH-1.
- Read path:
  - Word index = rd_addr[ADDR_W+1:2]; rd_misalign = |rd_addr[1:0].
  - A misaligned read still returns the aligned word; the core traps on it.
  - REG_READ=0: instruction = mem[index], combinational.
  - REG_READ=1: instruction and rd_misalign are registered at posedge, 1-cycle latency.
  - Reads are legal in every state. A read of a word being written in the same cycle returns the old contents (read-before-write) in both modes.
- rst asserted mid-CLEAR or mid-LOAD aborts the operation and restarts CLEAR from index 0; any partial load is discarded by the sweep.
- load_done and load_err are never both 1.

Test Plan:
- Reset, then hold idle: busy=1 for exactly DEPTH (256) cycles, then 0. Reads at 0x000 and 0x3FC return 0x00000000.
- load_base=4, load_count=3, stream 0x00500093, 0x00A00113, 0x002081B3 with valid gaps:
  - load_done rises on the edge after the 3rd accept.
  - rd_addr 0x010/0x014/0x018 return the three words.
  - rd_addr 0x00C and 0x01C still return 0.
- load_base=254, load_count=3 -> load_err=1, load_done=0, no memory change. Then load_base=254, load_count=2 succeeds; rd_addr 0x3FC returns the 2nd word.
- load_count=0 -> load_done=1 after one cycle, busy stays 0. load_start during LOAD is ignored; ptr and remaining are unchanged.
- REG_READ=1 build:
  - rd_addr=0x011 -> one cycle later instruction=mem[4] and rd_misalign=1.
  - Write mem[4] while reading it -> the old value is returned that cycle and the new value on the next.
- Assert rst after 2 of 5 words are loaded -> busy stays 1 for a full 256-cycle CLEAR, all words read 0, load_done=0.
